rng_digits_hs: RTL and testbench
================================

Name: rng_digits_hs

Overview:
Parametrised successor to the team's 4-digit LFSR digit generator. Produces a code word of NUM_DIGITS digits in range 0..RADIX-1 on request, using rejection sampling (no modulo bias) and a valid/ready handshake. The LFSR is seeded from a free-running counter captured at user-timed seed_en. It sits between the game controller (req/out_ready) and the display/compare logic (digits/out_valid).

Parameters:
LFSR_W, 16, LFSR and seed-counter width (>= DIGIT_W)
TAPS, 16'hB400, feedback tap mask (bit i set = lfsr[i] XORed into feedback)
SEED_DEFAULT, 16'hACE1, LFSR reset value and zero-seed substitute (nonzero)
NUM_DIGITS, 4, digits per code word
RADIX, 10, digit range 0..RADIX-1 (2 <= RADIX <= 2**DIGIT_W)
DIGIT_W, 4, bits per digit

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
seed_en  in  1  capture seed counter into LFSR (once per arm)
reseed  in  1  one-cycle pulse; re-arms seeding (clears seeded)
req  in  1  request new code word (level)
out_ready  in  1  consumer accepts code word
digits  out  NUM_DIGITS*DIGIT_W  code word; digit k at [k*DIGIT_W +: DIGIT_W]
out_valid  out  1  code word complete and stable
busy  out  1  high in FILL
seeded  out  1  LFSR has been loaded from the counter since reset/reseed

Behaviour:
- Reset (async): lfsr=SEED_DEFAULT, seed_cnt=0, seeded=0, digits=0, out_valid=0, busy=0, state=IDLE, slot index=0.
- seed_cnt: LFSR_W-bit, increments every cycle, wraps to 0; never stalls.
- LFSR step: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)}. Advances only in FILL (every FILL cycle, accepted or rejected); holds otherwise.
- Seeding: in IDLE, seed_en=1 and seeded=0 -> lfsr <= seed_cnt (SEED_DEFAULT if seed_cnt==0), seeded<=1. seed_en outside IDLE or with seeded=1 is ignored. reseed=1 clears seeded in any state, with no effect on lfsr; reseed and seed_en in the same cycle -> reseed wins.
- States: IDLE, FILL, VALID.
- IDLE: req=1 -> FILL, slot=0. If a seed load occurs in the same cycle, the first FILL sample sees the seeded value.
- FILL: candidate c = lfsr[DIGIT_W-1:0]. If c < RADIX, write it to digit[slot] and slot++; otherwise reject. The LFSR advances in both cases. Write to the last slot -> VALID next cycle (out_valid=1, busy=0).
- Latency: min NUM_DIGITS cycles from the FILL entry edge to out_valid; unbounded in principle, bounded in practice by a maximal LFSR.
- VALID: digits held stable and out_valid=1 until out_ready=1. out_ready=1 -> IDLE (out_valid=0 next cycle). With out_ready=1 and req=1 together -> FILL directly (back-to-back), slot=0.
- digits in FILL: earlier slots show new values; later slots keep the previous word. Consumers use digits only while out_valid=1.
- req is ignored in FILL/VALID except on the VALID+out_ready edge.
- Reset mid-FILL or mid-VALID: immediate return to reset values; partial word discarded.

Optional Feature:
RNG_UNIQUE_EN: when defined, the FILL acceptance condition additionally requires c to differ from every digit already written in the current word. All digits in a word are then distinct. Elaboration error if NUM_DIGITS > RADIX. When undefined, repeats are allowed; acceptance is only c < RADIX.

Test Plan:
- Reset, no seed_en, req=1 one cycle -> FILL samples lfsr ACE1,59C3,B387,670F,CE1E,9C3C,3879; rejects F,E,C; out_valid after 7 FILL cycles; digits=16'h9731 (same with RNG_UNIQUE_EN).
- Hold out_ready=0 for 20 cycles in VALID -> digits and out_valid stable; then out_ready=1 -> out_valid=0 next cycle, state IDLE.
- seed_en when seed_cnt==0 -> lfsr=ACE1, seeded=1. Then reseed pulse and seed_en at seed_cnt==16'h0005 -> lfsr=0005. seed_en in FILL -> no change.
- seed_en and req in the same IDLE cycle with seed_cnt=16'h1234 -> first FILL candidate=4 -> digit0=4.
- Assert rst 2 cycles into FILL -> out_valid=0, digits=0, busy=0, lfsr=ACE1 asynchronously. Next req reproduces 16'h9731.
- RNG_UNIQUE_EN, RADIX=4, NUM_DIGITS=4, 50 back-to-back words -> each word is a permutation of {0,1,2,3}. Without the macro -> at least one word contains a repeat.

Source files
------------

// File: rtl/rng_digits_hs_if.sv
// Handshake bundle between the game controller and the digit generator.
// The master side is the generator, which produces the code word and the status flags.
interface rng_digits_hs_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
);
  logic                          seed_en;
  logic                          reseed;
  logic                          req;
  logic                          out_ready;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits;
  logic                          out_valid;
  logic                          busy;
  logic                          seeded;

  modport master (
    input  seed_en, reseed, req, out_ready,
    output digits, out_valid, busy, seeded
  );

  modport slave (
    output seed_en, reseed, req, out_ready,
    input  digits, out_valid, busy, seeded
  );
endinterface

// File: rtl/rng_digits_hs.sv
// LFSR code-word generator with rejection-sampled digits; define RNG_UNIQUE_EN to force distinct digits.
// Latency is at least NUM_DIGITS FILL cycles; the word is held in VALID until out_ready, so backpressure only stalls.
module rng_digits_hs #(
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] TAPS         = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1,
  parameter int                NUM_DIGITS   = 4,
  parameter int                RADIX        = 10,
  parameter int                DIGIT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  rng_digits_hs_if.master       bus
);

  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIGIT_W:0] RADIX_V = (DIGIT_W+1)'(RADIX);

`ifdef RNG_UNIQUE_EN
  if (NUM_DIGITS > RADIX) begin : g_unique_chk
    $error("rng_digits_hs: NUM_DIGITS exceeds RADIX, distinct digits impossible");
  end
`endif

  typedef enum logic [1:0] {IDLE, FILL, VALID} state_t;

  state_t                        state;
  state_t                        state_nxt;
  logic [LFSR_W-1:0]             lfsr;
  logic [LFSR_W-1:0]             seed_cnt;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits_q;
  logic [SLOT_W-1:0]             slot;
  logic                          seeded_q;
  logic [DIGIT_W-1:0]            cand;
  logic                          in_range;
  logic                          cand_ok;
  logic                          last_slot;
  logic                          seed_load;

  assign cand      = lfsr[DIGIT_W-1:0];
  assign in_range  = {1'b0, cand} < RADIX_V;
  assign last_slot = (slot == SLOT_W'(NUM_DIGITS-1));

  // reseed has priority: a simultaneous seed_en must not re-arm and load in one go
  assign seed_load = (state == IDLE) && bus.seed_en && !seeded_q && !bus.reseed;

`ifdef RNG_UNIQUE_EN
  logic dup;
  always_comb begin
    dup = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((k < int'(slot)) && (digits_q[k*DIGIT_W +: DIGIT_W] == cand)) dup = 1'b1;
    end
  end
  assign cand_ok = in_range && !dup;
`else
  assign cand_ok = in_range;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req) state_nxt = FILL;
      FILL:    if (cand_ok && last_slot) state_nxt = VALID;
      VALID:   if (bus.out_ready) state_nxt = bus.req ? FILL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr     <= SEED_DEFAULT;
      seed_cnt <= '0;
      seeded_q <= 1'b0;
      digits_q <= '0;
      slot     <= '0;
    end else begin
      seed_cnt <= seed_cnt + 1'b1;

      if (bus.reseed)     seeded_q <= 1'b0;
      else if (seed_load) seeded_q <= 1'b1;

      // an all-zero seed would lock the LFSR, so substitute the default
      if (seed_load)            lfsr <= (seed_cnt == '0) ? SEED_DEFAULT : seed_cnt;
      else if (state == FILL)   lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};

      if (state == FILL) begin
        if (cand_ok) begin
          digits_q[slot*DIGIT_W +: DIGIT_W] <= cand;
          slot                              <= slot + 1'b1;
        end
      end else begin
        slot <= '0;
      end
    end
  end

  assign bus.digits    = digits_q;
  assign bus.out_valid = (state == VALID);
  assign bus.busy      = (state == FILL);
  assign bus.seeded    = seeded_q;

endmodule

// File: tb/tb_rng_digits_hs.sv
// Directed bench for rng_digits_hs: hand-computed LFSR words, seeding, hold, async reset,
// and a RADIX=4 instance run back-to-back for the distinct/repeat behaviour.
module tb_rng_digits_hs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rng_digits_hs_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus  ();
  rng_digits_hs_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus4 ();

  rng_digits_hs #(
    .LFSR_W(16), .TAPS(16'hB400), .SEED_DEFAULT(16'hACE1),
    .NUM_DIGITS(4), .RADIX(10), .DIGIT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  rng_digits_hs #(
    .LFSR_W(16), .TAPS(16'hB400), .SEED_DEFAULT(16'hACE1),
    .NUM_DIGITS(4), .RADIX(4), .DIGIT_W(4)
  ) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  int checks = 0;
  int errors = 0;

  // mirror of the free-running seed counter
  logic [15:0] cnt_model;
  always @(posedge clk or posedge rst) begin
    if (rst) cnt_model <= 16'h0000;
    else     cnt_model <= cnt_model + 16'd1;
  end

  typedef struct {
    logic        do_seed;
    logic [15:0] seed_at;
    logic [15:0] exp_d;
    int          exp_lat;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.seed_en = 1'b0; bus.reseed = 1'b0; bus.req = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cnt(input logic [15:0] target);
    for (int g = 0; g < 70000 && cnt_model != target; g++) @(negedge clk);
  endtask

  // Caller is on a negedge; req is raised here for one cycle.
  task automatic run_word(input logic with_seed, input logic mid_seed,
                          output logic [15:0] d, output int lat);
    bus.req     = 1'b1;
    bus.seed_en = with_seed;
    @(negedge clk);
    bus.req     = 1'b0;
    bus.seed_en = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.out_valid) break;
      if (bus.busy) lat++;
      if (mid_seed) begin
        bus.reseed  = (lat == 1);
        bus.seed_en = (lat == 2);
      end
      @(negedge clk);
    end
    bus.reseed  = 1'b0;
    bus.seed_en = 1'b0;
    d = bus.digits;
    check("word_valid", {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("accept_valid_low", {31'd0, bus.out_valid}, 32'd0);
    check("accept_idle",      {31'd0, bus.busy},      32'd0);
  endtask

  initial begin
    logic [15:0] d;
    int          lat;
    int          bad;
    int          words, range_bad, rep, b2b_bad;
    logic        prev_valid, has_rep;
    logic [3:0]  mask;
    logic [3:0]  dg;

    bus.seed_en = 1'b0; bus.reseed = 1'b0; bus.req = 1'b0; bus.out_ready = 1'b0;
    bus4.seed_en = 1'b0; bus4.reseed = 1'b0; bus4.req = 1'b0; bus4.out_ready = 1'b0;

    vecs[0] = '{1'b0, 16'h0000, 16'h9731, 7};
    vecs[1] = '{1'b1, 16'h0005, 16'h0845, 5};
`ifdef RNG_UNIQUE_EN
    vecs[2] = '{1'b1, 16'h1234, 16'h8294, 5};
`else
    vecs[2] = '{1'b1, 16'h1234, 16'h4294, 4};
`endif
    vecs[3] = '{1'b1, 16'h00FF, 16'h6318, 7};

    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    check("rst_seeded",    {31'd0, bus.seeded},    32'd0);
    check("rst_digits",    {16'd0, bus.digits},    32'd0);

    // table: fresh reset, optional seed_en together with req at a chosen counter value
    for (int v = 0; v < 4; v++) begin
      do_reset();
      if (vecs[v].do_seed) wait_cnt(vecs[v].seed_at);
      run_word(vecs[v].do_seed, 1'b0, d, lat);
      check($sformatf("vec%0d_digits", v), {16'd0, d}, {16'd0, vecs[v].exp_d});
      check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("vec%0d_seeded", v), {31'd0, bus.seeded}, {31'd0, vecs[v].do_seed});
      accept();
    end

    // zero seed substitutes the default, then VALID hold with req ignored
    do_reset();
    bus.seed_en = 1'b1;
    @(negedge clk);
    bus.seed_en = 1'b0;
    check("seed_zero_flag", {31'd0, bus.seeded}, 32'd1);
    run_word(1'b0, 1'b0, d, lat);
    check("seed_zero_digits", {16'd0, d}, 32'h9731);
    check("seed_zero_latency", lat, 7);
    bad = 0;
    bus.req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.digits !== 16'h9731 || bus.busy !== 1'b0) bad++;
    end
    bus.req = 1'b0;
    check("valid_hold", bad, 0);
    accept();

    // reseed clears seeded; reseed wins over a simultaneous seed_en
    bus.reseed = 1'b1;
    @(negedge clk);
    bus.reseed = 1'b0;
    check("reseed_clears", {31'd0, bus.seeded}, 32'd0);
    bus.reseed = 1'b1; bus.seed_en = 1'b1;
    @(negedge clk);
    bus.reseed = 1'b0; bus.seed_en = 1'b0;
    check("reseed_wins", {31'd0, bus.seeded}, 32'd0);
    wait_cnt(16'h00FF);
    bus.seed_en = 1'b1;
    @(negedge clk);
    bus.seed_en = 1'b0;
    check("reseed_reload_flag", {31'd0, bus.seeded}, 32'd1);
    // reseed then seed_en during FILL: flag drops, LFSR untouched
    run_word(1'b0, 1'b1, d, lat);
    check("fill_seed_digits", {16'd0, d}, 32'h6318);
    check("fill_seed_latency", lat, 7);
    check("fill_seed_flag", {31'd0, bus.seeded}, 32'd0);
    accept();

    // async reset two cycles into FILL
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    check("midfill_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("midfill_rst_valid",  {31'd0, bus.out_valid}, 32'd0);
    check("midfill_rst_busy",   {31'd0, bus.busy},      32'd0);
    check("midfill_rst_digits", {16'd0, bus.digits},    32'd0);
    check("midfill_rst_seeded", {31'd0, bus.seeded},    32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_word(1'b0, 1'b0, d, lat);
    check("after_rst_digits", {16'd0, d}, 32'h9731);
    check("after_rst_latency", lat, 7);
    accept();

    // RADIX=4 instance, 50 back-to-back words
    words = 0; range_bad = 0; rep = 0; b2b_bad = 0; prev_valid = 1'b0;
    bus4.req = 1'b1;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 20000 && words < 50; i++) begin
      @(negedge clk);
      if (prev_valid && bus4.busy !== 1'b1) b2b_bad++;
      prev_valid = bus4.out_valid;
      if (bus4.out_valid) begin
        words++;
        mask = 4'h0;
        has_rep = 1'b0;
        for (int k = 0; k < 4; k++) begin
          dg = bus4.digits[k*4 +: 4];
          if (dg >= 4'd4) range_bad++;
          if (mask[dg[1:0]]) has_rep = 1'b1;
          mask[dg[1:0]] = 1'b1;
        end
        if (has_rep) rep++;
      end
    end
    bus4.req = 1'b0;
    bus4.out_ready = 1'b0;
    check("r4_words", words, 50);
    check("r4_range", range_bad, 0);
    check("r4_back_to_back", b2b_bad, 0);
`ifdef RNG_UNIQUE_EN
    check("r4_unique_repeats", rep, 0);
`else
    check("r4_repeat_seen", {31'd0, (rep > 0)}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
